reset_responder: RTL and testbench
==================================

// Module: reset_responder
// PURPOSE
// Peripheral-side end of the per-peripheral soft-reset path. Takes the 9 level reset requests
// driven by the reset controller and turns each into a clean reset for its peripheral.
// Each reset is stretched to a minimum width, released, settled, then acknowledged.
// Exposes per-channel active/completion status and a completion counter on the MMIO bus.
// PARAMETERS
// N_CH           9   reset channels; bit 8 gpio,7 uart,6 sdcard,5 video,4 usb,3 psram,2 interrupt,1 timer,0 mmu
// HOLD_CYCLES   16   minimum cycles rst_out[i] stays high per request (>=1)
// SETTLE_CYCLES  4   cycles after release before completion is signalled (>=1)
// CNT_W         16   width of completed-reset counter
// PORTS
// clk        in   1      system clock
// rst        in   1      asynchronous, active-high reset
// rst_req    in   N_CH   level requests from reset controller, same bit order as above
// a          in   3      MMIO word address
// d          in   32     MMIO write data, big-endian byte order on bus
// we         in   1      MMIO write strobe, one cycle
// spo        out  32     MMIO read data, combinational from a, big-endian byte order
// rst_out    out  N_CH   stretched reset to each peripheral, registered
// done       out  N_CH   one-cycle completion pulse per channel, registered
// BEHAVIOUR
// - Bus bytes swapped both ways: data = {d[7:0],d[15:8],d[23:16],d[31:24]}; spo = same swap of internal word.
// - Per-channel FSM: IDLE, ASSERT, SETTLE. Counter per channel, width clog2(max(HOLD,SETTLE)+1).
// - rst asserted (async): all channels -> ASSERT, counter=HOLD_CYCLES-1, rst_out=all 1, done=0,
//   sticky=0, count=0. So every peripheral gets a full HOLD+SETTLE sequence after rst drops.
// - IDLE: rst_out[i]=0. rst_req[i]=1 -> ASSERT, rst_out[i]=1 next cycle, counter=HOLD_CYCLES-1.
// - ASSERT: rst_out[i]=1; counter decrements to 0 and holds. Exit only when counter==0 AND
//   rst_req[i]==0 -> SETTLE, counter=SETTLE_CYCLES-1, rst_out[i]=0 next cycle.
//   Request held longer than HOLD -> reset held for request duration (level follows request).
// - SETTLE: counter decrements; rst_req[i]=1 in any SETTLE cycle -> back to ASSERT, reload HOLD,
//   no done. counter==0 and rst_req[i]==0 -> IDLE with done[i]=1 for exactly that one cycle.
// - Minimum request-to-done latency (1-cycle request): HOLD_CYCLES+SETTLE_CYCLES+1 cycles.
// - Completion: done[i] pulse sets sticky[i]; count += popcount(done pulses that cycle), saturating at 2^CNT_W-1.
// - Register map (word addr a):
//   0 R   status: [N_CH-1:0] = channel not IDLE; upper bits 0
//   1 R/W1C sticky completion flags; write data[i]=1 clears sticky[i]; same-cycle set wins over clear
//   2 R/W count in [CNT_W-1:0]; any write clears to 0; same-cycle increment after clear gives popcount
//   3 R   parameters: [31:24]=N_CH, [23:16]=HOLD_CYCLES[7:0], [15:8]=SETTLE_CYCLES[7:0], [7:0]=0
//   4-7   read 0, writes ignored
// - Writes never affect FSMs; channels are independent and may run concurrently.
// - rst mid-sequence: immediately forces ASSERT with fresh HOLD load, no done pulse for aborted sequence.
// STRUCTURE
// - Package reset_responder_pkg: FSM state encoding (IDLE/ASSERT/SETTLE), register address constants
//   (REG_STATUS=0, REG_STICKY=1, REG_COUNT=2, REG_INFO=3), channel index constants matching bit order.
// - Sub-module reset_responder_ch: one channel FSM + counter (rst_req, rst_out, done, busy),
//   instantiated N_CH times by generate. Top holds sticky, count, byte swap and read mux.
// TESTING
// - rst high 3 cycles then low, rst_req=0 -> rst_out=9'h1FF for 16 cycles after rst low, then 0;
//   done=9'h1FF one cycle 4 cycles later; reg2 reads 9 (spo byte-swapped: 32'h09000000).
// - rst_req[7] one-cycle pulse -> rst_out[7] high 16 cycles, done[7] at cycle 21 from request;
//   status reads bit7 set during sequence; sticky bit7 set after.
// - rst_req[3] held 40 cycles -> rst_out[3] high 40 cycles (not 16), done[3] 5 cycles after drop.
// - rst_req[0] re-pulsed 2 cycles into SETTLE -> rst_out[0] re-asserts for full 16, exactly one done[0].
// - Write reg1 with data 9'h080 same cycle done[7] fires -> sticky bit7 stays 1; next write clears it.
// - Preload count to 16'hFFFE via 2 completions after forcing CNT_W=1 build? No: use CNT_W=2, 5 completions -> reads 3 (saturated).

Source files
------------

// File: rtl/reset_responder_pkg.sv
// Shared definitions for the per-peripheral reset responder: channel FSM
// states, MMIO register addresses, channel bit positions and the bus byte swap.
package reset_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ASSERT = 2'd1,
        ST_SETTLE = 2'd2
    } ch_state_t;

    localparam logic [2:0] REG_STATUS = 3'd0;
    localparam logic [2:0] REG_STICKY = 3'd1;
    localparam logic [2:0] REG_COUNT  = 3'd2;
    localparam logic [2:0] REG_INFO   = 3'd3;

    localparam int CH_MMU       = 0;
    localparam int CH_TIMER     = 1;
    localparam int CH_INTERRUPT = 2;
    localparam int CH_PSRAM     = 3;
    localparam int CH_USB       = 4;
    localparam int CH_VIDEO     = 5;
    localparam int CH_SDCARD    = 6;
    localparam int CH_UART      = 7;
    localparam int CH_GPIO      = 8;

    // The MMIO bus is big-endian; internal words are little-endian.
    function automatic logic [31:0] byte_swap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/reset_responder_ch.sv
// One reset channel: stretches a level request to at least HOLD_CYCLES,
// waits SETTLE_CYCLES after release, then pulses done for one cycle.
module reset_responder_ch
    import reset_responder_pkg::*;
#(
    parameter int HOLD_CYCLES   = 16,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic rst_req,
    output logic rst_out,
    output logic done,
    output logic busy
);

    localparam int MAX_LOAD = (HOLD_CYCLES > SETTLE_CYCLES) ? HOLD_CYCLES : SETTLE_CYCLES;
    localparam int CW       = $clog2(MAX_LOAD + 1);
    localparam logic [CW-1:0] HOLD_LOAD   = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYCLES - 1);

    ch_state_t     state, state_next;
    logic [CW-1:0] cnt, cnt_next;
    logic          done_next;

    // State, counter and registered outputs; reset starts a full hold sequence.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_ASSERT;
            cnt     <= HOLD_LOAD;
            rst_out <= 1'b1;
            done    <= 1'b0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            rst_out <= (state_next == ST_ASSERT);
            done    <= done_next;
        end
    end

    // Next-state logic: hold counts down and parks at zero until the request drops.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        done_next  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (rst_req) begin
                    state_next = ST_ASSERT;
                    cnt_next   = HOLD_LOAD;
                end
            end
            ST_ASSERT: begin
                if (cnt == '0) begin
                    if (!rst_req) begin
                        state_next = ST_SETTLE;
                        cnt_next   = SETTLE_LOAD;
                    end
                end else begin
                    cnt_next = cnt - CW'(1);
                end
            end
            ST_SETTLE: begin
                if (rst_req) begin
                    state_next = ST_ASSERT;
                    cnt_next   = HOLD_LOAD;
                end else if (cnt == '0) begin
                    state_next = ST_IDLE;
                    done_next  = 1'b1;
                end else begin
                    cnt_next = cnt - CW'(1);
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign busy = (state != ST_IDLE);

endmodule

// File: rtl/reset_responder.sv
// Peripheral-side soft-reset responder: N_CH independent reset channels plus
// MMIO status, sticky completion flags and a saturating completion counter.
module reset_responder
    import reset_responder_pkg::*;
#(
    parameter int N_CH          = 9,
    parameter int HOLD_CYCLES   = 16,
    parameter int SETTLE_CYCLES = 4,
    parameter int CNT_W         = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] rst_req,
    input  logic [2:0]      a,
    input  logic [31:0]     d,
    input  logic            we,
    output logic [31:0]     spo,
    output logic [N_CH-1:0] rst_out,
    output logic [N_CH-1:0] done
);

    localparam int PC_W  = $clog2(N_CH + 1);
    localparam int SUM_W = CNT_W + PC_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [N_CH-1:0]  busy;
    logic [N_CH-1:0]  sticky, sticky_next;
    logic [N_CH-1:0]  clr_mask;
    logic [CNT_W-1:0] count, count_next, count_base;
    logic [PC_W-1:0]  pc;
    logic [SUM_W-1:0] sum;
    logic [31:0]      rdata;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        reset_responder_ch #(
            .HOLD_CYCLES  (HOLD_CYCLES),
            .SETTLE_CYCLES(SETTLE_CYCLES)
        ) u_ch (
            .clk    (clk),
            .rst    (rst),
            .rst_req(rst_req[i]),
            .rst_out(rst_out[i]),
            .done   (done[i]),
            .busy   (busy[i])
        );
    end

    assign clr_mask = (we && a == REG_STICKY) ? N_CH'(byte_swap(d)) : '0;

    // Sticky flags and completion count; a same-cycle completion beats a clear.
    always_comb begin
        pc = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            pc = pc + PC_W'(done[i]);
        end
        sticky_next = (sticky & ~clr_mask) | done;
        count_base  = (we && a == REG_COUNT) ? '0 : count;
        sum         = SUM_W'(count_base) + SUM_W'(pc);
        count_next  = (sum > SUM_W'(CNT_MAX)) ? CNT_MAX : sum[CNT_W-1:0];
    end

    // Completion bookkeeping registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sticky <= '0;
            count  <= '0;
        end else begin
            sticky <= sticky_next;
            count  <= count_next;
        end
    end

    // Read mux; unmapped addresses read zero.
    always_comb begin
        rdata = '0;
        case (a)
            REG_STATUS: rdata[N_CH-1:0]  = busy;
            REG_STICKY: rdata[N_CH-1:0]  = sticky;
            REG_COUNT:  rdata[CNT_W-1:0] = count;
            REG_INFO:   rdata = {8'(N_CH), 8'(HOLD_CYCLES), 8'(SETTLE_CYCLES), 8'h00};
            default:    rdata = '0;
        endcase
        spo = byte_swap(rdata);
    end

endmodule

// File: tb/tb_reset_responder.sv
// Directed self-checking bench for reset_responder (default build plus a
// CNT_W=2 build for counter saturation).
module tb_reset_responder;
    import reset_responder_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [8:0]  rst_req;
    logic [2:0]  a;
    logic [31:0] d;
    logic        we;
    logic [31:0] spo;
    logic [8:0]  rst_out;
    logic [8:0]  done;

    logic [8:0]  s_req;
    logic [2:0]  s_a;
    logic [31:0] s_d;
    logic        s_we;
    logic [31:0] s_spo;
    logic [8:0]  s_rst_out;
    logic [8:0]  s_done;

    int n_checks = 0;
    int n_errors = 0;

    reset_responder dut (
        .clk(clk), .rst(rst), .rst_req(rst_req), .a(a), .d(d), .we(we),
        .spo(spo), .rst_out(rst_out), .done(done)
    );

    reset_responder #(.CNT_W(2)) dut_small (
        .clk(clk), .rst(rst), .rst_req(s_req), .a(s_a), .d(s_d), .we(s_we),
        .spo(s_spo), .rst_out(s_rst_out), .done(s_done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [2:0] addr, input logic [31:0] val);
        a  = addr;
        d  = val;
        we = 1'b1;
        tick();
        we = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [2:0] addr, input logic [31:0] exp);
        a = addr;
        #1;
        check(tag, spo, exp);
    endtask

    task automatic wait_done(input int ch, output int cyc);
        cyc = -1;
        for (int c = 1; c <= 60; c++) begin
            tick();
            if (done[ch]) begin
                cyc = c;
                break;
            end
        end
    endtask

    task automatic run_req(input int ch, input int len, input int rep_at,
                           output int lat, output int hi, output int ndone,
                           output logic [31:0] mid);
        lat = -1; hi = 0; ndone = 0; mid = '0;
        a = REG_STATUS;
        rst_req[ch] = 1'b1;
        for (int c = 1; c <= 200; c++) begin
            tick();
            if (c == len) rst_req[ch] = 1'b0;
            if (rep_at > 0 && c == rep_at) rst_req[ch] = 1'b1;
            if (rep_at > 0 && c == rep_at + 1) rst_req[ch] = 1'b0;
            if (c == 5) mid = spo;
            if (rst_out[ch]) hi++;
            if (done[ch]) begin
                ndone++;
                if (lat < 0) lat = c;
            end
            if (lat >= 0 && c >= lat + 3) break;
        end
        rst_req[ch] = 1'b0;
    endtask

    initial begin
        int hi, lat, nd, cyc, exp_cnt;
        logic [31:0] mid;

        rst = 1'b1; rst_req = '0; a = '0; d = '0; we = 1'b0;
        s_req = '0; s_a = '0; s_d = '0; s_we = 1'b0;

        // Asynchronous reset state before any clock edge
        #1;
        check("async_rst_out", 32'(rst_out), 32'h1FF);
        check("async_done", 32'(done), 32'h0);
        rd("rst_count", REG_COUNT, 32'h0);
        repeat (3) tick();
        rst = 1'b0;

        // Post-reset sequence on all channels
        hi = 0;
        if (rst_out == 9'h1FF) hi = 1;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (rst_out == 9'h1FF) hi++;
            else break;
        end
        check("post_rst_hold", 32'(hi), 32'd16);
        check("post_rst_release", 32'(rst_out), 32'h0);
        cyc = -1;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (done != '0) begin
                cyc = c;
                break;
            end
        end
        check("post_rst_settle", 32'(cyc), 32'd4);
        check("post_rst_done", 32'(done), 32'h1FF);
        tick();
        check("post_rst_done_1cyc", 32'(done), 32'h0);
        rd("rst_count9", REG_COUNT, 32'h09000000);
        rd("rst_sticky", REG_STICKY, 32'hFF010000);
        rd("rst_status", REG_STATUS, 32'h0);
        rd("info", REG_INFO, 32'h00041009);

        // Small build: 9 completions saturate a 2-bit counter
        s_a = REG_COUNT;
        #1;
        check("s_count_sat9", s_spo, 32'h03000000);
        s_d = 32'h0; s_we = 1'b1;
        tick();
        s_we = 1'b0;
        #1;
        check("s_count_clr", s_spo, 32'h0);
        for (int k = 0; k < 5; k++) begin
            s_req[k] = 1'b1;
            tick();
            s_req[k] = 1'b0;
            cyc = -1;
            for (int c = 1; c <= 40; c++) begin
                tick();
                if (s_done[k]) begin
                    cyc = c;
                    break;
                end
            end
            check("s_done_lat", 32'(cyc), 32'd20);
            tick();
            exp_cnt = (k + 1 > 3) ? 3 : k + 1;
            s_a = REG_COUNT;
            #1;
            check("s_count", s_spo, {exp_cnt[7:0], 24'h0});
        end

        // Clear sticky flags, then a one-cycle uart request
        bus_write(REG_STICKY, 32'hFF010000);
        rd("sticky_clr", REG_STICKY, 32'h0);
        run_req(CH_UART, 1, 0, lat, hi, nd, mid);
        check("uart_lat", 32'(lat), 32'd21);
        check("uart_hold", 32'(hi), 32'd16);
        check("uart_ndone", 32'(nd), 32'd1);
        check("uart_status_mid", mid, 32'h80000000);
        rd("uart_sticky", REG_STICKY, 32'h80000000);
        rd("uart_count", REG_COUNT, 32'h0A000000);

        // Long psram request: reset follows the request level
        run_req(CH_PSRAM, 40, 0, lat, hi, nd, mid);
        check("psram_lat", 32'(lat), 32'd45);
        check("psram_hold", 32'(hi), 32'd40);
        check("psram_ndone", 32'(nd), 32'd1);
        check("psram_status_mid", mid, 32'h08000000);

        // mmu re-requested two cycles into settle
        run_req(CH_MMU, 1, 18, lat, hi, nd, mid);
        check("mmu_lat", 32'(lat), 32'd39);
        check("mmu_hold", 32'(hi), 32'd32);
        check("mmu_ndone", 32'(nd), 32'd1);
        check("mmu_status_mid", mid, 32'h01000000);
        rd("sticky_3ch", REG_STICKY, 32'h89000000);

        // Sticky clear in the same cycle as a new completion
        bus_write(REG_STICKY, 32'hFF010000);
        rst_req[CH_UART] = 1'b1;
        tick();
        rst_req[CH_UART] = 1'b0;
        wait_done(CH_UART, cyc);
        check("w1c_done_lat", 32'(cyc), 32'd20);
        bus_write(REG_STICKY, 32'h80000000);
        rd("w1c_set_wins", REG_STICKY, 32'h80000000);
        bus_write(REG_STICKY, 32'h80000000);
        rd("w1c_clear", REG_STICKY, 32'h0);

        // Count clear in the same cycle as two completions
        rst_req[CH_TIMER] = 1'b1;
        rst_req[CH_INTERRUPT] = 1'b1;
        tick();
        rst_req[CH_TIMER] = 1'b0;
        rst_req[CH_INTERRUPT] = 1'b0;
        wait_done(CH_TIMER, cyc);
        check("pair_done", 32'(done), 32'h006);
        bus_write(REG_COUNT, 32'h12345678);
        rd("count_clr_plus2", REG_COUNT, 32'h02000000);

        // Unmapped addresses
        bus_write(3'd5, 32'hFFFFFFFF);
        rd("unmapped5", 3'd5, 32'h0);
        rd("unmapped7", 3'd7, 32'h0);
        rd("count_kept", REG_COUNT, 32'h02000000);

        // Reset in the middle of a video sequence
        rst_req[CH_VIDEO] = 1'b1;
        tick();
        rst_req[CH_VIDEO] = 1'b0;
        repeat (8) tick();
        rst = 1'b1;
        #1;
        check("midrst_rst_out", 32'(rst_out), 32'h1FF);
        check("midrst_done", 32'(done), 32'h0);
        tick();
        rst = 1'b0;
        rd("midrst_status", REG_STATUS, 32'hFF010000);
        wait_done(CH_VIDEO, cyc);
        check("midrst_lat", 32'(cyc), 32'd20);
        check("midrst_all_done", 32'(done), 32'h1FF);
        tick();
        rd("midrst_count", REG_COUNT, 32'h09000000);
        rd("midrst_sticky", REG_STICKY, 32'hFF010000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
